// File: rtl/pmu_event_conditioner.sv
// -----------------------------------------------------------------------------
// pmu_event_conditioner
//
// Conditions raw core event levels before they reach the PMU event inputs.
// Each lane is registered once, debounced by a per-lane stability filter, and
// then reduced to a level or a one-cycle edge pulse according to its mode.
// Raw changes that vanish before the filter accepts them are counted as
// glitches in a shared saturating counter.
//
// Ports
//   clk_i         : clock, all state updates on its rising edge
//   rst_i         : asynchronous active-high reset
//   raw_events_i  : [N_EVENTS]   raw event levels, synchronous to clk_i
//   mode_i        : [2*N_EVENTS] per-lane mode at [2i+1:2i]
//                   00 off, 01 level, 10 rising edge, 11 falling edge
//   filter_thr_i  : [CNT_W]      cycles a change must persist (0 and 1 = none)
//   enable_i      : global output enable
//   clear_i       : synchronous clear of the glitch counter
//   events_o      : [N_EVENTS]   conditioned, registered events
//   glitch_cnt_o  : [GLITCH_W]   saturating count of cycles with a rejected glitch
// -----------------------------------------------------------------------------
module pmu_event_conditioner #(
  parameter int N_EVENTS = 19,
  parameter int CNT_W    = 4,
  parameter int GLITCH_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_EVENTS-1:0]   raw_events_i,
  input  logic [2*N_EVENTS-1:0] mode_i,
  input  logic [CNT_W-1:0]      filter_thr_i,
  input  logic                  enable_i,
  input  logic                  clear_i,
  output logic [N_EVENTS-1:0]   events_o,
  output logic [GLITCH_W-1:0]   glitch_cnt_o
);

  localparam logic [CNT_W-1:0]    CNT_ONE    = 1;
  localparam logic [GLITCH_W-1:0] GLITCH_ONE = 1;

  logic [N_EVENTS-1:0] raw_q,    raw_d;
  logic [N_EVENTS-1:0] filt_q,   filt_d;
  logic [N_EVENTS-1:0] prev_q,   prev_d;
  logic [N_EVENTS-1:0] events_q, events_d;
  logic [CNT_W-1:0]    cnt_q [N_EVENTS];
  logic [CNT_W-1:0]    cnt_d [N_EVENTS];
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic [N_EVENTS-1:0] glitch_lane;

  // Largest count still allowed before a pending change is accepted.
  // Threshold 0 and 1 both collapse to 0, i.e. accept on first disagreement.
  logic [CNT_W-1:0] limit;
  assign limit = (filter_thr_i == '0) ? '0 : (filter_thr_i - CNT_ONE);

  assign raw_d = raw_events_i;
  assign prev_d = filt_q;

  for (genvar gi = 0; gi < N_EVENTS; gi++) begin : g_lane
    logic [1:0]       lane_mode;
    logic             filt_n;
    logic             glitch_n;
    logic             event_n;
    logic [CNT_W-1:0] cnt_n;

    assign lane_mode = mode_i[2*gi +: 2];

    always_comb begin
      filt_n   = filt_q[gi];
      cnt_n    = cnt_q[gi];
      glitch_n = 1'b0;
      if (raw_q[gi] == filt_q[gi]) begin
        // Raw fell back to the accepted level: any partial count was a glitch.
        cnt_n    = '0;
        glitch_n = (cnt_q[gi] != '0);
      end else if (cnt_q[gi] >= limit) begin
        // ">=" so that a lowered threshold accepts immediately.
        filt_n = raw_q[gi];
        cnt_n  = '0;
      end else begin
        // cnt stays below limit here, so the increment cannot wrap.
        cnt_n = cnt_q[gi] + CNT_ONE;
      end
    end

    // Output uses the registered filt and the one-cycle-older prev, giving
    // edge pulses that are exactly one cycle wide and one register stage
    // after acceptance.
    always_comb begin
      event_n = 1'b0;
      if (enable_i) begin
        unique case (lane_mode)
          2'b00:   event_n = 1'b0;
          2'b01:   event_n = filt_q[gi];
          2'b10:   event_n = filt_q[gi] & ~prev_q[gi];
          default: event_n = ~filt_q[gi] & prev_q[gi];
        endcase
      end
    end

    assign filt_d[gi]      = filt_n;
    assign cnt_d[gi]       = cnt_n;
    assign glitch_lane[gi] = glitch_n;
    assign events_d[gi]    = event_n;
  end

  // One increment per cycle regardless of how many lanes glitched; clear wins.
  always_comb begin
    glitch_d = glitch_q;
    if (clear_i) begin
      glitch_d = '0;
    end else if ((|glitch_lane) && (glitch_q != '1)) begin
      glitch_d = glitch_q + GLITCH_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      raw_q    <= '0;
      filt_q   <= '0;
      prev_q   <= '0;
      events_q <= '0;
      glitch_q <= '0;
      for (int i = 0; i < N_EVENTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      raw_q    <= raw_d;
      filt_q   <= filt_d;
      prev_q   <= prev_d;
      events_q <= events_d;
      glitch_q <= glitch_d;
      for (int i = 0; i < N_EVENTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign events_o     = events_q;
  assign glitch_cnt_o = glitch_q;

endmodule

// File: tb/tb_pmu_event_conditioner.sv
module tb_pmu_event_conditioner;

  localparam int N  = 19;
  localparam int CW = 4;
  localparam int GW = 16;
  localparam int GMAX = (1 << GW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  raw = '0;
  logic [2*N-1:0] mode = '0;
  logic [CW-1:0] thr = '0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic [N-1:0]  ev;
  logic [GW-1:0] gcnt;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b1;

  always #5 clk = ~clk;

  pmu_event_conditioner #(.N_EVENTS(N), .CNT_W(CW), .GLITCH_W(GW)) dut (
    .clk_i(clk), .rst_i(rst), .raw_events_i(raw), .mode_i(mode),
    .filter_thr_i(thr), .enable_i(en), .clear_i(clr),
    .events_o(ev), .glitch_cnt_o(gcnt)
  );

  // ---------------- reference model ----------------
  // Per lane: the sampled raw level, the accepted level, the accepted level one
  // cycle ago, and how many consecutive cycles raw has disagreed with it.
  bit           m_raw_q [N];
  bit           m_filt  [N];
  bit           m_prev  [N];
  int           m_run   [N];
  logic [N-1:0] m_ev;
  int           m_glitch;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_raw_q[i] = 0; m_filt[i] = 0; m_prev[i] = 0; m_run[i] = 0;
    end
    m_ev = '0;
    m_glitch = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [2*N-1:0] m,
                            input logic [CW-1:0] th, input logic e, input logic c);
    int t;
    bit hit;
    logic [N-1:0] nev;
    t = (th == 0) ? 1 : int'(th);
    nev = '0;
    for (int i = 0; i < N; i++) begin
      logic [1:0] md;
      md = m[2*i +: 2];
      if (e) begin
        if (md == 2'b01) nev[i] = m_filt[i];
        else if (md == 2'b10) nev[i] = m_filt[i] && !m_prev[i];
        else if (md == 2'b11) nev[i] = !m_filt[i] && m_prev[i];
      end
    end
    hit = 0;
    for (int i = 0; i < N; i++) begin
      m_prev[i] = m_filt[i];
      if (m_raw_q[i] != m_filt[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] >= t) begin
          m_filt[i] = m_raw_q[i];
          m_run[i] = 0;
        end
      end else begin
        if (m_run[i] > 0) hit = 1;
        m_run[i] = 0;
      end
      m_raw_q[i] = r[i];
    end
    m_ev = nev;
    if (c) m_glitch = 0;
    else if (hit) m_glitch = (m_glitch >= GMAX) ? GMAX : m_glitch + 1;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*N-1:0] lane_mode(input int lane, input logic [1:0] md);
    logic [2*N-1:0] v;
    v = '0;
    v[2*lane +: 2] = md;
    return v;
  endfunction

  task automatic step(input logic [N-1:0] r, input logic [2*N-1:0] m,
                      input logic [CW-1:0] th, input logic e, input logic c);
    raw = r; mode = m; thr = th; en = e; clr = c;
    @(posedge clk);
    #1;
    model_step(r, m, th, e, c);
    if (chk_on) begin
      check("model_events", 32'(ev), 32'(m_ev));
      check("model_glitch", 32'(gcnt), 32'(m_glitch));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_events", 32'(ev), 32'h0);
    check("rst_glitch", 32'(gcnt), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- table ----------------
  typedef struct {
    logic [N-1:0]   raw;
    logic [2*N-1:0] mode;
    logic [CW-1:0]  thr;
    logic           en;
    logic           clr;
    logic [N-1:0]   exp_ev;
    logic [GW-1:0]  exp_gl;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [2*N-1:0] m01, m10, m11, md;
    logic [N-1:0]   r;
    logic [63:0]    w64;

    m01 = lane_mode(3, 2'b01);
    m10 = lane_mode(3, 2'b10);
    m11 = lane_mode(3, 2'b11);
    // Lane 3, no filtering: level appears on the third edge after raw is driven;
    // mode changes take effect on the next edge; falling pulse in mode 11.
    tbl[0] = '{19'h0, m01, 4'd0, 1'b1, 1'b0, 19'h0, 16'h0};
    tbl[1] = '{19'h8, m01, 4'd0, 1'b1, 1'b0, 19'h0, 16'h0};
    tbl[2] = '{19'h8, m01, 4'd0, 1'b1, 1'b0, 19'h0, 16'h0};
    tbl[3] = '{19'h8, m01, 4'd0, 1'b1, 1'b0, 19'h8, 16'h0};
    tbl[4] = '{19'h8, m10, 4'd0, 1'b1, 1'b0, 19'h0, 16'h0};
    tbl[5] = '{19'h8, m01, 4'd0, 1'b1, 1'b0, 19'h8, 16'h0};
    tbl[6] = '{19'h0, m01, 4'd0, 1'b1, 1'b0, 19'h8, 16'h0};
    tbl[7] = '{19'h0, m01, 4'd0, 1'b1, 1'b0, 19'h8, 16'h0};
    tbl[8] = '{19'h0, m11, 4'd0, 1'b1, 1'b0, 19'h8, 16'h0};
    tbl[9] = '{19'h0, m11, 4'd0, 1'b1, 1'b0, 19'h0, 16'h0};

    #2;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].raw, tbl[i].mode, tbl[i].thr, tbl[i].en, tbl[i].clr);
      check($sformatf("tbl_ev[%0d]", i), 32'(ev), 32'(tbl[i].exp_ev));
      check($sformatf("tbl_gl[%0d]", i), 32'(gcnt), 32'(tbl[i].exp_gl));
    end

    // thr=4, lane 0 rising: 3-cycle blip is a glitch, 4-cycle high is one pulse.
    do_reset();
    md = lane_mode(0, 2'b10);
    for (int s = 1; s <= 3; s++) begin
      step(19'h1, md, 4'd4, 1'b1, 1'b0);
      check("blip_no_pulse", 32'(ev[0]), 32'h0);
    end
    for (int s = 1; s <= 6; s++) begin
      step(19'h0, md, 4'd4, 1'b1, 1'b0);
      check("blip_no_pulse", 32'(ev[0]), 32'h0);
    end
    check("blip_glitch", 32'(gcnt), 32'h1);
    for (int s = 1; s <= 10; s++) begin
      step((s <= 4) ? 19'h1 : 19'h0, md, 4'd4, 1'b1, 1'b0);
      check($sformatf("thr4_pulse_s%0d", s), 32'(ev[0]), (s == 6) ? 32'h1 : 32'h0);
    end
    check("thr4_glitch_kept", 32'(gcnt), 32'h1);

    // Lanes 1 and 2 glitch together -> +1; clear together with glitch -> 0.
    do_reset();
    step(19'h6, '0, 4'd4, 1'b1, 1'b0);
    step(19'h0, '0, 4'd4, 1'b1, 1'b0);
    step(19'h0, '0, 4'd4, 1'b1, 1'b0);
    step(19'h0, '0, 4'd4, 1'b1, 1'b0);
    check("dual_glitch_once", 32'(gcnt), 32'h1);
    step(19'h6, '0, 4'd4, 1'b1, 1'b0);
    step(19'h0, '0, 4'd4, 1'b1, 1'b0);
    step(19'h0, '0, 4'd4, 1'b1, 1'b1);
    check("clear_beats_glitch", 32'(gcnt), 32'h0);

    // thr=8, lane 5 builds count 5 toward a 1->0 change, thr lowered to 3.
    do_reset();
    md = lane_mode(5, 2'b11);
    for (int s = 0; s < 12; s++) step(19'h20, md, 4'd8, 1'b1, 1'b0);
    for (int s = 0; s < 6; s++) step(19'h0, md, 4'd8, 1'b1, 1'b0);
    step(19'h0, md, 4'd3, 1'b1, 1'b0);
    check("thr_drop_e7", 32'(ev[5]), 32'h0);
    step(19'h0, md, 4'd3, 1'b1, 1'b0);
    check("thr_drop_fall_pulse", 32'(ev[5]), 32'h1);
    step(19'h0, md, 4'd3, 1'b1, 1'b0);
    check("thr_drop_pulse_end", 32'(ev[5]), 32'h0);

    // Lane 7 rising edge while disabled is suppressed; re-enable stays quiet.
    do_reset();
    md = lane_mode(7, 2'b10);
    for (int s = 0; s < 5; s++) begin
      step(19'h80, md, 4'd1, 1'b0, 1'b0);
      check("disabled_quiet", 32'(ev), 32'h0);
    end
    for (int s = 0; s < 4; s++) begin
      step(19'h80, md, 4'd1, 1'b1, 1'b0);
      check("reenable_quiet", 32'(ev[7]), 32'h0);
    end

    // Reset mid-filter discards the count; raw held high after reset is a rise.
    do_reset();
    md = lane_mode(0, 2'b10);
    for (int s = 0; s < 3; s++) step(19'h1, md, 4'd4, 1'b1, 1'b0);
    do_reset();
    for (int s = 1; s <= 9; s++) begin
      step(19'h1, md, 4'd4, 1'b1, 1'b0);
      check($sformatf("post_rst_pulse_s%0d", s), 32'(ev[0]), (s == 6) ? 32'h1 : 32'h0);
    end

    // Randomised run against the model.
    do_reset();
    r = '0;
    w64 = {$urandom, $urandom};
    md = w64[2*N-1:0];
    thr = 4'($urandom_range(0, 4));
    for (int s = 0; s < 3000; s++) begin
      logic [N-1:0] flip;
      logic [CW-1:0] th;
      flip = N'($urandom & $urandom);
      r = r ^ flip;
      if ($urandom_range(0, 29) == 0) begin
        w64 = {$urandom, $urandom};
        md = w64[2*N-1:0];
      end
      th = thr;
      if ($urandom_range(0, 19) == 0) th = 4'($urandom_range(0, 4));
      step(r, md, th, ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    // Glitch counter saturation: lanes 1 and 2 toggle in antiphase so one of
    // them rejects a glitch every cycle from the third edge on.
    do_reset();
    chk_on = 1'b0;
    for (int s = 1; s <= 65536; s++) begin
      step((s % 2 == 1) ? 19'h2 : 19'h4, '0, 4'd15, 1'b1, 1'b0);
    end
    chk_on = 1'b1;
    check("sat_before", 32'(gcnt), 32'hFFFE);
    step(19'h2, '0, 4'd15, 1'b1, 1'b0);
    check("sat_reach", 32'(gcnt), 32'hFFFF);
    for (int s = 0; s < 3; s++) begin
      step((s % 2 == 0) ? 19'h4 : 19'h2, '0, 4'd15, 1'b1, 1'b0);
      check("sat_hold", 32'(gcnt), 32'hFFFF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pmu_event_conditioner.md
PMU_EVENT_CONDITIONER -- requirements
Module: pmu_event_conditioner

Interface
REQ-001 SHALL have parameter N_EVENTS, default 19, the number of event lanes conditioned and fed to the PMU event inputs (EV0_i..EV18_i).
REQ-002 SHALL have parameter CNT_W, default 4, the width of the per-lane filter counter and of filter_thr_i.
REQ-003 SHALL have parameter GLITCH_W, default 16, the width of the glitch counter.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; ports clk_i and rst_i.
REQ-005 clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 rst_i  input  1  asynchronous active-high reset.
REQ-007 raw_events_i  input  N_EVENTS  raw core event levels; synchronous to clk_i.
REQ-008 mode_i  input  2*N_EVENTS  per-lane mode, lane i at bits [2i+1:2i]: 00 off, 01 level, 10 rising edge, 11 falling edge.
REQ-009 filter_thr_i  input  CNT_W  stability threshold in cycles; 0 and 1 both mean no filtering.
REQ-010 enable_i  input  1  global output enable.
REQ-011 clear_i  input  1  synchronous clear of the glitch counter.
REQ-012 events_o  output  N_EVENTS  conditioned, registered events, one bit per PMU event input.
REQ-013 glitch_cnt_o  output  GLITCH_W  saturating count of cycles in which at least one glitch was rejected.

Function
REQ-014 SHALL register raw_events_i into raw_q on every edge (stage 1).
REQ-015 Per lane, state SHALL be filt (accepted level), cnt (CNT_W bits) and prev (filt delayed by one cycle).
REQ-016 If raw_q == filt, cnt SHALL load 0.
REQ-017 If raw_q != filt and cnt >= max(filter_thr_i,1)-1, filt SHALL load raw_q and cnt SHALL load 0.
REQ-018 If raw_q != filt and cnt is below that limit, cnt SHALL increment; cnt SHALL never wrap.
REQ-019 Effect of REQ-016..018: a raw change persisting T=max(thr,1) consecutive cycles is accepted at edge 1+T after the raw change is sampled.
REQ-020 A lane whose raw_q returns to filt while cnt != 0 SHALL count as a rejected glitch.
REQ-021 A lowered filter_thr_i SHALL take effect on the next edge; any lane with cnt already at or beyond the new limit SHALL accept on that edge.
REQ-022 prev SHALL load filt every edge.
REQ-023 events_o[i] SHALL be registered: mode 00 -> 0; 01 -> filt; 10 -> filt & ~prev; 11 -> ~filt & prev.
REQ-024 events_o[i] SHALL be computed from the post-update filt and the pre-update prev, so edge pulses are exactly one cycle wide.
REQ-025 End-to-end latency SHALL be 2+T cycles from raw_events_i change to events_o.
REQ-026 When enable_i=0, events_o SHALL be 0 from the next edge; filt, cnt and prev SHALL keep updating, and no spurious edge pulse SHALL occur on re-enable unless filt actually changed that cycle.
REQ-027 A mode_i change SHALL affect events_o at the next edge only; no state is reset by a mode change.
REQ-028 glitch_cnt_o SHALL increment by 1 on any edge where at least one lane rejects a glitch, regardless of how many lanes do so.
REQ-029 glitch_cnt_o SHALL saturate at all-ones.
REQ-030 clear_i SHALL take priority over increment and load glitch_cnt_o with 0.

Reset
REQ-031 While rst_i=1, raw_q, filt, prev, cnt, events_o and glitch_cnt_o SHALL all be 0, asynchronously.
REQ-032 After rst_i is released, a lane whose raw input is held at 1 SHALL be treated as a 0->1 change: mode 10 produces one pulse after 2+T cycles.
REQ-033 Reset asserted mid-filter SHALL discard the partial count.

Verification
REQ-034 thr=0, lane 3 mode 01, raw 0->1 sampled at edge k -> events_o[3]=1 from edge k+3.
REQ-035 thr=4, lane 0 mode 10, raw high for 3 cycles then low -> no pulse, glitch_cnt_o=1; raw then high for 4 cycles -> a single 1-cycle pulse at edge k+6.
REQ-036 Lanes 1 and 2 both glitch in the same cycle -> glitch_cnt_o increments by exactly 1; clear_i asserted together with a glitch -> glitch_cnt_o=0.
REQ-037 Force 0xFFFF glitches (GLITCH_W=16) then one more -> glitch_cnt_o stays 0xFFFF.
REQ-038 thr=8 with lane 5 cnt=5, thr changed to 3 -> filt[5] accepted on the next edge; mode 11 on a 1->0 change -> one-cycle pulse.
REQ-039 enable_i=0 during a rising edge on lane 7 (mode 10) -> pulse suppressed; re-enable with raw steady -> events_o[7] stays 0.
